sme_job_sched: RTL and testbench



---
 rtl/sme_pkg.sv | 27 ++
 rtl/sme_rr_arbiter.sv | 33 +++
 rtl/sme_job_sched.sv | 270 +++++++++++++++++++++++++++
 tb/tb_sme_job_sched.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sme_pkg.sv
// Shared types and constants for the string-matching-engine (SME) job scheduler.
//   sched_state_e : scheduler FSM states
//   char_t        : one engine character
//   WORD_*        : engine meta-characters
//   IDX_W         : engine match-index width
package sme_pkg;

  localparam int unsigned IDX_W = 5;

  typedef logic [7:0] char_t;

  localparam char_t WORD_START = 8'h5E;  // '^'
  localparam char_t WORD_END   = 8'h24;  // '$'
  localparam char_t WORD_ANY   = 8'h2E;  // '.'
  localparam char_t WORD_SPACE = 8'h20;  // ' '

  typedef enum logic [2:0] {
    StIdle,
    StGrant,
    StStr,
    StPat,
    StReject,
    StWait,
    StResp
  } sched_state_e;

endpackage

// File: rtl/sme_rr_arbiter.sv
// Combinational round-robin picker.
//   i_req       : pending requests
//   i_last_gnt  : index of the last requester served; search starts one above it, with wrap
//   i_en        : when low, no grant is produced
//   o_gnt_next  : one-hot winner (all zero if no request or not enabled)
module sme_rr_arbiter
  import sme_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         i_req,
  input  logic [$clog2(N_REQ)-1:0] i_last_gnt,
  input  logic                     i_en,
  output logic [N_REQ-1:0]         o_gnt_next
);

  localparam int unsigned GW = $clog2(N_REQ);

  // Walk the ring from farthest to nearest so the nearest hit overwrites the rest.
  always_comb begin : p_arb
    logic [GW-1:0] w_idx;
    o_gnt_next = '0;
    w_idx      = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_idx = GW'((int'(i_last_gnt) + k) % N_REQ);
      if (i_en && i_req[w_idx]) begin
        o_gnt_next        = '0;
        o_gnt_next[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sme_job_sched.sv
// Round-robin scheduler sharing one string-matching engine among N_REQ requesters.
// The granted requester's char stream is forwarded to the engine through one register
// stage; the engine result is returned to the owner as a one-cycle rsp_valid pulse.
// The requester that last loaded a string owns it; pattern-only jobs from anyone else
// are rejected with rsp_err.
//
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   i_req / o_gnt         : per-requester job request / one-hot grant
//   i_in_char             : per-requester char, slice i = [8i+7:8i]
//   i_in_isstring/ispattern : per-requester string / pattern strobes
//   o_rsp_valid           : one-cycle result pulse to the owner
//   o_rsp_match/index/err : result, valid with o_rsp_valid
//   o_busy                : scheduler not idle
//   o_eng_*               : char stream to the engine
//   i_eng_valid/match/match_index : engine result
//
// Optional build macro SME_SCHED_WATCHDOG_EN: bounds the wait for the engine result to
// WDOG_CYCLES cycles, then answers with rsp_err and forgets the string owner.
module sme_job_sched
  import sme_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned STR_MAX     = 32,
  parameter int unsigned PAT_MAX     = 8,
  parameter int unsigned WDOG_CYCLES = 512
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   i_req,
  output logic [N_REQ-1:0]   o_gnt,
  input  logic [8*N_REQ-1:0] i_in_char,
  input  logic [N_REQ-1:0]   i_in_isstring,
  input  logic [N_REQ-1:0]   i_in_ispattern,
  output logic [N_REQ-1:0]   o_rsp_valid,
  output logic               o_rsp_match,
  output logic [IDX_W-1:0]   o_rsp_index,
  output logic               o_rsp_err,
  output logic               o_busy,
  output char_t              o_eng_chardata,
  output logic               o_eng_isstring,
  output logic               o_eng_ispattern,
  input  logic               i_eng_valid,
  input  logic               i_eng_match,
  input  logic [IDX_W-1:0]   i_eng_match_index
);

  localparam int unsigned GW  = $clog2(N_REQ);
  localparam int unsigned SCW = $clog2(STR_MAX + 1);
  localparam int unsigned PCW = $clog2(PAT_MAX + 1);
  localparam logic [SCW-1:0] STR_MAX_C = SCW'(STR_MAX);
  localparam logic [PCW-1:0] PAT_MAX_C = PCW'(PAT_MAX);

  sched_state_e     r_state;
  logic [N_REQ-1:0] r_gnt;
  logic [GW-1:0]    r_g;
  logic [GW-1:0]    r_last_gnt;
  logic [GW-1:0]    r_str_owner;
  logic             r_str_owner_vld;
  logic [SCW-1:0]   r_str_cnt;
  logic [PCW-1:0]   r_pat_cnt;
  logic             r_err_flag;
  char_t            r_eng_chardata;
  logic             r_eng_isstring;
  logic             r_eng_ispattern;
  logic [N_REQ-1:0] r_rsp_valid;
  logic             r_rsp_match;
  logic [IDX_W-1:0] r_rsp_index;
  logic             r_rsp_err;

  logic [N_REQ-1:0] w_gnt_next;
  logic [GW-1:0]    w_gnt_idx;
  char_t            w_sel_char;
  logic             w_sel_req;
  logic             w_sel_str;
  logic             w_sel_pat_raw;
  logic             w_sel_pat;

`ifdef SME_SCHED_WATCHDOG_EN
  localparam int unsigned WDW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(WDOG_CYCLES - 1);
  logic [WDW-1:0] r_wdog_cnt;
`else
  logic w_unused_wdog;
  assign w_unused_wdog = ^WDOG_CYCLES;
`endif

  sme_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .i_req      (i_req),
    .i_last_gnt (r_last_gnt),
    .i_en       (r_state == StIdle),
    .o_gnt_next (w_gnt_next)
  );

  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt_next[i]) w_gnt_idx = GW'(i);
    end
  end

  // Only the granted lane is looked at.
  always_comb begin
    w_sel_char    = '0;
    w_sel_req     = 1'b0;
    w_sel_str     = 1'b0;
    w_sel_pat_raw = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_g == GW'(i)) begin
        w_sel_char    = i_in_char[8*i +: 8];
        w_sel_req     = i_req[i];
        w_sel_str     = i_in_isstring[i];
        w_sel_pat_raw = i_in_ispattern[i];
      end
    end
  end

  // A string strobe wins over a simultaneous pattern strobe.
  assign w_sel_pat = w_sel_pat_raw & ~w_sel_str;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= StIdle;
      r_gnt           <= '0;
      r_g             <= '0;
      r_last_gnt      <= GW'(N_REQ - 1);
      r_str_owner     <= '0;
      r_str_owner_vld <= 1'b0;
      r_str_cnt       <= '0;
      r_pat_cnt       <= '0;
      r_err_flag      <= 1'b0;
      r_eng_chardata  <= '0;
      r_eng_isstring  <= 1'b0;
      r_eng_ispattern <= 1'b0;
      r_rsp_valid     <= '0;
      r_rsp_match     <= 1'b0;
      r_rsp_index     <= '0;
      r_rsp_err       <= 1'b0;
`ifdef SME_SCHED_WATCHDOG_EN
      r_wdog_cnt      <= '0;
`endif
    end else begin
      r_eng_chardata  <= '0;
      r_eng_isstring  <= 1'b0;
      r_eng_ispattern <= 1'b0;
      r_rsp_valid     <= '0;
      case (r_state)
        StIdle: begin
          if (|w_gnt_next) begin
            r_gnt      <= w_gnt_next;
            r_g        <= w_gnt_idx;
            r_err_flag <= 1'b0;
            r_state    <= StGrant;
          end
        end
        StGrant: begin
          if (w_sel_str) begin
            // A new string overwrites the resident one, so its old owner is gone.
            r_str_owner_vld <= 1'b0;
            r_eng_chardata  <= w_sel_char;
            r_eng_isstring  <= 1'b1;
            r_str_cnt       <= SCW'(1);
            r_state         <= StStr;
          end else if (w_sel_pat) begin
            if (r_str_owner_vld && (r_str_owner == r_g)) begin
              r_eng_chardata  <= w_sel_char;
              r_eng_ispattern <= 1'b1;
              r_pat_cnt       <= PCW'(1);
              r_state         <= StPat;
            end else begin
              r_state <= StReject;
            end
          end else if (!w_sel_req) begin
            r_gnt   <= '0;
            r_state <= StIdle;
          end
        end
        StStr: begin
          if (w_sel_pat) begin
            r_str_owner     <= r_g;
            r_str_owner_vld <= 1'b1;
            r_eng_chardata  <= w_sel_char;
            r_eng_ispattern <= 1'b1;
            r_pat_cnt       <= PCW'(1);
            r_state         <= StPat;
          end else if (w_sel_str) begin
            if (r_str_cnt < STR_MAX_C) begin
              r_eng_chardata <= w_sel_char;
              r_eng_isstring <= 1'b1;
              r_str_cnt      <= r_str_cnt + SCW'(1);
            end else begin
              r_err_flag <= 1'b1;
            end
          end
        end
        StPat: begin
          if (w_sel_pat_raw) begin
            if (r_pat_cnt < PAT_MAX_C) begin
              r_eng_chardata  <= w_sel_char;
              r_eng_ispattern <= 1'b1;
              r_pat_cnt       <= r_pat_cnt + PCW'(1);
            end else begin
              r_err_flag <= 1'b1;
            end
          end else begin
`ifdef SME_SCHED_WATCHDOG_EN
            r_wdog_cnt <= '0;
`endif
            r_state <= StWait;
          end
        end
        StReject: begin
          if (!w_sel_pat_raw) begin
            r_rsp_valid <= r_gnt;
            r_rsp_err   <= 1'b1;
            r_rsp_match <= 1'b0;
            r_rsp_index <= '0;
            r_gnt       <= '0;
            r_state     <= StResp;
          end
        end
        StWait: begin
          if (i_eng_valid) begin
            r_rsp_valid <= r_gnt;
            r_rsp_match <= i_eng_match;
            r_rsp_index <= i_eng_match_index;
            r_rsp_err   <= r_err_flag;
            r_gnt       <= '0;
            r_state     <= StResp;
          end
`ifdef SME_SCHED_WATCHDOG_EN
          else if (r_wdog_cnt == WDOG_LAST) begin
            // Engine never answered; its string contents can no longer be trusted.
            r_rsp_valid     <= r_gnt;
            r_rsp_match     <= 1'b0;
            r_rsp_index     <= '0;
            r_rsp_err       <= 1'b1;
            r_str_owner_vld <= 1'b0;
            r_gnt           <= '0;
            r_state         <= StResp;
          end else begin
            r_wdog_cnt <= r_wdog_cnt + WDW'(1);
          end
`endif
        end
        StResp: begin
          r_rsp_match <= 1'b0;
          r_rsp_index <= '0;
          r_rsp_err   <= 1'b0;
          r_last_gnt  <= r_g;
          r_state     <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_gnt           = r_gnt;
  assign o_rsp_valid     = r_rsp_valid;
  assign o_rsp_match     = r_rsp_match;
  assign o_rsp_index     = r_rsp_index;
  assign o_rsp_err       = r_rsp_err;
  assign o_busy          = (r_state != StIdle);
  assign o_eng_chardata  = r_eng_chardata;
  assign o_eng_isstring  = r_eng_isstring;
  assign o_eng_ispattern = r_eng_ispattern;

endmodule

// File: tb/tb_sme_job_sched.sv
// Directed bench for sme_job_sched with a behavioural string-matching engine attached.
// Expected responses go into a scoreboard queue when a job is started and are popped by
// a monitor when rsp_valid pulses.
module tb_sme_job_sched;

  localparam int N    = 4;
  localparam int WDOG = 512;
  localparam string S40 = "abcdefghijklmnopqrstuvwxyzabcdefghijklmn";

  logic           clk;
  logic           reset;
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic [8*N-1:0] in_char;
  logic [N-1:0]   in_isstring;
  logic [N-1:0]   in_ispattern;
  logic [N-1:0]   rsp_valid;
  logic           rsp_match;
  logic [4:0]     rsp_index;
  logic           rsp_err;
  logic           busy;
  logic [7:0]     eng_chardata;
  logic           eng_isstring;
  logic           eng_ispattern;
  logic           eng_valid;
  logic           eng_match;
  logic [4:0]     eng_match_index;

  logic [25:0] outs;
  assign outs = {gnt, rsp_valid, rsp_match, rsp_index, rsp_err, busy,
                 eng_chardata, eng_isstring, eng_ispattern};

  sme_job_sched #(
    .N_REQ       (N),
    .STR_MAX     (32),
    .PAT_MAX     (8),
    .WDOG_CYCLES (WDOG)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .i_req             (req),
    .o_gnt             (gnt),
    .i_in_char         (in_char),
    .i_in_isstring     (in_isstring),
    .i_in_ispattern    (in_ispattern),
    .o_rsp_valid       (rsp_valid),
    .o_rsp_match       (rsp_match),
    .o_rsp_index       (rsp_index),
    .o_rsp_err         (rsp_err),
    .o_busy            (busy),
    .o_eng_chardata    (eng_chardata),
    .o_eng_isstring    (eng_isstring),
    .o_eng_ispattern   (eng_ispattern),
    .i_eng_valid       (eng_valid),
    .i_eng_match       (eng_match),
    .i_eng_match_index (eng_match_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         owner;
    logic       match;
    logic [4:0] idx;
    logic       err;
  } exp_t;
  exp_t sb[$];

  // Engine model state
  logic [7:0] m_str[$];
  logic [7:0] m_pat[$];
  bit         m_str_open = 0;
  bit         m_pat_on   = 0;
  bit         m_ok;
  int         m_pend     = 0;
  bit         eng_en     = 1;
  int         n_str      = 0;
  int         n_pat      = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int o, input logic m, input logic [4:0] i, input logic e);
    exp_t x;
    x.owner = o;
    x.match = m;
    x.idx   = i;
    x.err   = e;
    sb.push_back(x);
  endtask

  // Waits for any grant, then streams the job on the granted lane.
  task automatic send_job(input string s, input string p, output int g);
    int n = 0;
    while (gnt == '0 && n < 50) begin
      tick();
      n++;
    end
    chk("gnt_timeout", 32'(n < 50), 1);
    g = 0;
    for (int i = 0; i < N; i++) if (gnt[i]) g = i;
    tick();
    for (int i = 0; i < s.len(); i++) begin
      in_isstring[g]     = 1'b1;
      in_char[8*g +: 8]  = s[i];
      tick();
    end
    in_isstring[g] = 1'b0;
    for (int i = 0; i < p.len(); i++) begin
      in_ispattern[g]    = 1'b1;
      in_char[8*g +: 8]  = p[i];
      tick();
    end
    in_ispattern[g]   = 1'b0;
    in_char[8*g +: 8] = 8'h00;
  endtask

  task automatic wait_rsp(input int g, input int limit, output int n);
    n = 0;
    while (!rsp_valid[g] && n < limit) begin
      tick();
      n++;
    end
    chk("rsp_timeout", 32'(n < limit), 1);
  endtask

  // Behavioural engine: a pattern is matched against the resident string once its
  // stream ends; the result comes back a few cycles later.
  initial begin
    eng_valid       = 1'b0;
    eng_match       = 1'b0;
    eng_match_index = '0;
    forever begin
      @(negedge clk);
      eng_valid = 1'b0;
      if (reset) begin
        m_pend     = 0;
        m_str_open = 0;
        m_pat_on   = 0;
        m_str.delete();
        m_pat.delete();
      end else begin
        if (m_pend > 0) begin
          m_pend--;
          if (m_pend == 0) eng_valid = 1'b1;
        end
        if (eng_isstring) begin
          n_str++;
          if (!m_str_open) begin
            m_str.delete();
            m_str_open = 1;
          end
          m_str.push_back(eng_chardata);
        end else if (eng_ispattern) begin
          n_pat++;
          m_str_open = 0;
          m_pat_on   = 1;
          m_pat.push_back(eng_chardata);
        end else if (m_pat_on) begin
          m_pat_on = 0;
          if (eng_en) begin
            eng_match       = 1'b0;
            eng_match_index = '0;
            for (int s = 0; s + m_pat.size() <= m_str.size(); s++) begin
              m_ok = 1;
              for (int j = 0; j < m_pat.size(); j++) if (m_str[s+j] != m_pat[j]) m_ok = 0;
              if (m_ok && !eng_match) begin
                eng_match       = 1'b1;
                eng_match_index = 5'(s);
              end
            end
            m_pend = 3;
          end
          m_pat.delete();
        end
      end
    end
  end

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && rsp_valid != '0) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 0);
        end else begin
          e = sb.pop_front();
          chk("rsp_owner", 32'(rsp_valid), 32'(1) << e.owner);
          chk("rsp_match", 32'(rsp_match), 32'(e.match));
          chk("rsp_index", 32'(rsp_index), 32'(e.idx));
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
    end
  end

  initial begin
    int g;
    int n;
    int s0;
    int p0;
    reset        = 1'b1;
    req          = '0;
    in_char      = '0;
    in_isstring  = '0;
    in_ispattern = '0;
    repeat (3) tick();
    chk("reset_outputs", 32'(outs), 0);
    reset = 1'b0;
    tick();
    chk("idle_outputs", 32'(outs), 0);

    // Single job: grant one cycle after req, "hello world" / "wor" -> index 6
    req[0] = 1'b1;
    tick();
    chk("a_gnt_next_cycle", 32'(gnt), 32'b0001);
    chk("a_busy", 32'(busy), 1);
    push_exp(0, 1'b1, 5'd6, 1'b0);
    send_job("hello world", "wor", g);
    wait_rsp(g, 200, n);
    req[0] = 1'b0;
    tick();
    chk("a_gnt_cleared", 32'(gnt), 0);

    // Reset while waiting on a silent engine: everything drops at once
    eng_en = 0;
    req[1] = 1'b1;
    send_job("xy", "y", g);
    chk("rw_owner", 32'(g), 1);
    repeat (3) tick();
    chk("rw_busy_in_wait", 32'(busy), 1);
    #3 reset = 1'b1;
    #1;
    chk("rw_reset_outputs", 32'(outs), 0);
    req = '0;
    tick();
    reset  = 1'b0;
    eng_en = 1;
    tick();

    // All requesters pending: round-robin order 0,1,2,3,0
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      push_exp(k % 4, 1'b1, 5'd1, 1'b0);
      send_job("ab", "b", g);
      chk("rr_order", 32'(g), 32'(k % 4));
      wait_rsp(g, 200, n);
    end
    req = '0;
    tick();

    // String ownership: requester 2 owns "abc"; requester 1 pattern-only is rejected
    req[2] = 1'b1;
    push_exp(2, 1'b1, 5'd1, 1'b0);
    send_job("abc", "b", g);
    chk("own_load_owner", 32'(g), 2);
    wait_rsp(g, 200, n);
    req[2] = 1'b0;
    tick();
    req[1] = 1'b1;
    push_exp(1, 1'b0, 5'd0, 1'b1);
    s0 = n_str + n_pat;
    send_job("", "b", g);
    chk("own_reject_owner", 32'(g), 1);
    wait_rsp(g, 200, n);
    chk("own_reject_no_eng", 32'(n_str + n_pat - s0), 0);
    req[1] = 1'b0;
    tick();
    req[2] = 1'b1;
    push_exp(2, 1'b1, 5'd2, 1'b0);
    send_job("", "c", g);
    chk("own_reuse_owner", 32'(g), 2);
    wait_rsp(g, 200, n);
    req[2] = 1'b0;
    tick();

    // 40-char string: only 32 reach the engine, error flagged with the result
    req[0] = 1'b1;
    push_exp(0, 1'b1, 5'd25, 1'b1);
    s0 = n_str;
    p0 = n_pat;
    send_job(S40, "zab", g);
    wait_rsp(g, 300, n);
    req[0] = 1'b0;
    chk("ovf_str_strobes", 32'(n_str - s0), 32);
    chk("ovf_pat_strobes", 32'(n_pat - p0), 3);
    tick();

    // Requester 3 granted then withdraws; requester 1 is next
    req = 4'b1000;
    n   = 0;
    while (!gnt[3] && n < 20) begin
      tick();
      n++;
    end
    chk("drop_gnt3", 32'(gnt), 32'b1000);
    req = 4'b0010;
    tick();
    chk("drop_gnt_cleared", 32'(gnt), 0);
    chk("drop_not_busy", 32'(busy), 0);
    chk("drop_no_rsp", 32'(rsp_valid), 0);
    tick();
    chk("drop_next_gnt", 32'(gnt), 32'b0010);
    push_exp(1, 1'b1, 5'd0, 1'b0);
    send_job("qq", "q", g);
    wait_rsp(g, 200, n);
    req = '0;
    tick();

`ifdef SME_SCHED_WATCHDOG_EN
    // Silent engine: error response exactly WDOG cycles after entering the wait
    eng_en = 0;
    req[0] = 1'b1;
    push_exp(0, 1'b0, 5'd0, 1'b1);
    send_job("ab", "b", g);
    tick();
    n = 0;
    while (!rsp_valid[0] && n < WDOG + 20) begin
      tick();
      n++;
    end
    chk("wdog_latency", 32'(n), 32'(WDOG));
    req    = '0;
    eng_en = 1;
    tick();
`endif

    repeat (3) tick();
    chk("sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
